// File: rtl/word_assembler.sv
// Groups tokenizer characters into whitespace-separated words of up to MAX_WORD bytes.
// Each character costs a request cycle and a capture cycle. While a word waits for its ack, no more characters are pulled.
module word_assembler #(
    parameter  int MAX_WORD = 16,
    localparam int WIDTH    = 8,
    localparam int LEN_BITS = $clog2(MAX_WORD + 1)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_en,
    input  logic [WIDTH-1:0]          i_data,
    input  logic                      i_data_ready,
    input  logic                      i_wc,
    input  logic                      i_eol,
    output logic                      o_next,
    output logic [WIDTH*MAX_WORD-1:0] o_word,
    output logic [LEN_BITS-1:0]       o_word_len,
    output logic                      o_word_eol,
    output logic                      o_word_trunc,
    output logic                      o_word_valid,
    input  logic                      i_word_ack
);

    typedef enum logic [1:0] {IDLE, REQ, CAPTURE, EMIT} state_t;

    localparam logic [LEN_BITS-1:0] MAX_LEN = LEN_BITS'(MAX_WORD);

    state_t                      state, state_nxt;
    logic [WIDTH*MAX_WORD-1:0]   word_buf;
    logic [LEN_BITS-1:0]         count;
    logic                        trunc;
    logic                        eol_q;
    logic                        eol_sent;

    logic store, drop, emit, emit_eol, set_sent, clr_sent, clr_word;

    always_comb begin
        state_nxt = state;
        store     = 1'b0;
        drop      = 1'b0;
        emit      = 1'b0;
        emit_eol  = 1'b0;
        set_sent  = 1'b0;
        clr_sent  = 1'b0;
        clr_word  = 1'b0;
        case (state)
            IDLE: begin
                if (i_data_ready) begin
                    clr_sent  = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (i_data_ready) begin
                    state_nxt = CAPTURE;
                end else if (count != '0 || !eol_sent) begin
                    // Line ran dry: close it exactly once, either with the pending word or a len-0 marker.
                    emit      = 1'b1;
                    emit_eol  = 1'b1;
                    set_sent  = 1'b1;
                    state_nxt = EMIT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            CAPTURE: begin
                if (i_eol) begin
                    emit      = 1'b1;
                    emit_eol  = 1'b1;
                    set_sent  = 1'b1;
                    state_nxt = EMIT;
                end else if (i_wc) begin
                    if (count != '0) begin
                        emit      = 1'b1;
                        state_nxt = EMIT;
                    end else begin
                        state_nxt = REQ;
                    end
                end else begin
                    if (count < MAX_LEN) store = 1'b1;
                    else                 drop  = 1'b1;
                    state_nxt = REQ;
                end
            end
            EMIT: begin
                if (i_word_ack) begin
                    clr_word  = 1'b1;
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            word_buf <= '0;
            count    <= '0;
            trunc    <= 1'b0;
            eol_q    <= 1'b0;
            eol_sent <= 1'b0;
        end else if (i_en) begin
            state <= state_nxt;
            if (store) begin
                for (int k = 0; k < MAX_WORD; k++) begin
                    if (count == LEN_BITS'(k)) word_buf[k*WIDTH +: WIDTH] <= i_data;
                end
                count <= count + 1'b1;
            end
            if (drop)     trunc    <= 1'b1;
            if (emit)     eol_q    <= emit_eol;
            if (set_sent) eol_sent <= 1'b1;
            if (clr_sent) eol_sent <= 1'b0;
            if (clr_word) begin
                word_buf <= '0;
                count    <= '0;
                trunc    <= 1'b0;
            end
        end
    end

    assign o_next       = (state == REQ) && i_data_ready && i_en;
    assign o_word       = word_buf;
    assign o_word_len   = count;
    assign o_word_eol   = eol_q;
    assign o_word_trunc = trunc;
    assign o_word_valid = (state == EMIT);

endmodule

// File: tb/tb_word_assembler.sv
// Directed bench for word_assembler: a behavioural tokenizer feeds text lines, words are checked against hand-computed values.
module tb_word_assembler;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_en = 1'b1;
    logic [7:0]   i_data = '0;
    logic         i_data_ready = 1'b0;
    logic         i_wc = 1'b0;
    logic         i_eol = 1'b0;
    logic         o_next;
    logic [127:0] o_word;
    logic [4:0]   o_word_len;
    logic         o_word_eol;
    logic         o_word_trunc;
    logic         o_word_valid;
    logic         i_word_ack = 1'b0;

    int    total = 0;
    int    bad = 0;
    string line = "";
    int    idx = 0;

    word_assembler #(.MAX_WORD(16)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_data(i_data),
        .i_data_ready(i_data_ready), .i_wc(i_wc), .i_eol(i_eol), .o_next(o_next),
        .o_word(o_word), .o_word_len(o_word_len), .o_word_eol(o_word_eol),
        .o_word_trunc(o_word_trunc), .o_word_valid(o_word_valid), .i_word_ack(i_word_ack)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock; the tokenizer presents the next character on the edge that samples o_next.
    task automatic tick();
        logic nxt_seen;
        byte  c;
        @(negedge i_clk);
        nxt_seen = o_next;
        @(posedge i_clk);
        #1;
        if (nxt_seen && idx < line.len()) begin
            c      = line[idx];
            i_data = c;
            i_wc   = (c == 8'h20);
            i_eol  = (c == 8'h0A);
            idx++;
            i_data_ready = (idx < line.len());
        end
    endtask

    task automatic load_line(input string s);
        line         = s;
        idx          = 0;
        i_data_ready = (s.len() > 0);
    endtask

    task automatic expect_word(input string tag, input logic [127:0] w, input int len,
                               input logic eol, input logic tr);
        int n = 0;
        while (!o_word_valid && n < 300) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, o_word_valid, 1);
        chk({tag, "_word"},  o_word, w);
        chk({tag, "_len"},   o_word_len, len);
        chk({tag, "_eol"},   o_word_eol, eol);
        chk({tag, "_trunc"}, o_word_trunc, tr);
        chk({tag, "_next"},  o_next, 0);
        i_word_ack = 1'b1;
        tick();
        i_word_ack = 1'b0;
        chk({tag, "_drop"},  o_word_valid, 0);
    endtask

    task automatic quiet(input string tag, input int cycles);
        int seen_v = 0;
        int seen_n = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            seen_v += int'(o_word_valid);
            seen_n += int'(o_next);
        end
        chk({tag, "_novalid"}, seen_v, 0);
        chk({tag, "_nonext"},  seen_n, 0);
    endtask

    initial begin
        int nreq;
        logic [127:0] held;
        #2;
        chk("rst_valid", o_word_valid, 0);
        chk("rst_next",  o_next, 0);
        chk("rst_word",  o_word, 0);
        chk("rst_len",   o_word_len, 0);
        chk("rst_eol",   o_word_eol, 0);
        chk("rst_trunc", o_word_trunc, 0);
        tick();
        i_rst = 1'b0;
        tick();

        load_line("DUP 2\n");
        expect_word("dup", 128'h505544, 3, 0, 0);
        expect_word("two", 128'h32, 1, 1, 0);
        quiet("dup_idle", 10);

        load_line("  A   B");
        expect_word("a", 128'h41, 1, 0, 0);
        expect_word("b", 128'h42, 1, 1, 0);
        quiet("ab_idle", 20);

        load_line("\n");
        expect_word("nl", 128'h0, 0, 1, 0);
        quiet("nl_idle", 10);

        load_line("X \n");
        expect_word("x", 128'h58, 1, 0, 0);
        expect_word("x_mark", 128'h0, 0, 1, 0);
        quiet("x_idle", 10);

        load_line("ABCDEFGHIJKLMNOPQRST\n");
        expect_word("long", 128'h504F4E4D4C4B4A494847464544434241, 16, 1, 1);
        quiet("long_idle", 10);

        // Backpressure: hold the word for 10 cycles with no ack.
        load_line("HI J\n");
        nreq = 0;
        while (!o_word_valid && nreq < 300) begin
            tick();
            nreq++;
        end
        chk("bp_valid", o_word_valid, 1);
        held = o_word;
        chk("bp_word", held, 128'h4948);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_hold_valid", o_word_valid, 1);
            chk("bp_hold_word",  o_word, 128'h4948);
            chk("bp_hold_len",   o_word_len, 2);
            chk("bp_hold_next",  o_next, 0);
        end
        i_word_ack = 1'b1;
        tick();
        i_word_ack = 1'b0;
        chk("bp_ack_valid", o_word_valid, 0);
        chk("bp_ack_next",  o_next, 1);
        expect_word("j", 128'h4A, 1, 1, 0);
        quiet("j_idle", 10);

        // Reset during CAPTURE of the second character.
        load_line("ABC\n");
        nreq = 0;
        for (int i = 0; i < 50 && nreq < 2; i++) begin
            if (o_next) nreq++;
            tick();
        end
        chk("mid_reqs", nreq, 2);
        i_rst = 1'b1;
        #1;
        chk("mid_word",  o_word, 0);
        chk("mid_len",   o_word_len, 0);
        chk("mid_valid", o_word_valid, 0);
        chk("mid_next",  o_next, 0);
        load_line("");
        tick();
        i_rst = 1'b0;
        quiet("mid_after", 10);
        chk("mid_after_word", o_word, 0);

        // Enable low while in REQ.
        load_line("Q\n");
        tick();
        chk("en_req_next", o_next, 1);
        i_en = 1'b0;
        #1;
        chk("en_off_next", o_next, 0);
        quiet("en_off", 5);
        i_en = 1'b1;
        #1;
        chk("en_back_next", o_next, 1);
        expect_word("q", 128'h51, 1, 1, 0);
        quiet("q_idle", 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
